// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller.
// Holds MIPS ExcCode values, cp0 register indices, Status/Cause bit
// positions and the controller FSM state type.
package exc_ctrl_pkg;

  // ExcCode values written to Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // cp0 register indices
  localparam int unsigned CP0_BADVADDR = 8;
  localparam int unsigned CP0_STATUS   = 12;
  localparam int unsigned CP0_CAUSE    = 13;
  localparam int unsigned CP0_EPC      = 14;

  // Status / Cause bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned CAUSE_SW_LO  = 8;
  localparam int unsigned CAUSE_SW_HI  = 9;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/exc_ctrl_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous interrupt lines.
// Ports: clk, rst (async, active-high), d_i (raw lines), q_o (STAGES-deep copy).
module exc_sync #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // NOTE: this is a short flop chain, not a RAM, so every stage is reset;
  // storage arrays inferred as memories would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller.
// Prioritises exception flags and synchronised interrupts, produces the cp0
// commit strobe and write values, flushes IF..MEM and hands a redirect target
// to fetch through a valid/ready handshake.
// Ports: clk/rst; hw_int -> hw_int_sync; cp0_* read values in; mem_* describe
// the MEM instruction; exc_* flags and is_eret; cp0_* commit outputs;
// flush; redirect_valid/redirect_ready/redirect_pc handshake.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc_r,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [31:0] mem_addr,
  input  logic        exc_if_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_ld_adel,
  input  logic        exc_st_ades,
  input  logic        is_eret,
  input  logic        redirect_ready,
  output logic [5:0]  hw_int_sync,
  output logic        cp0_en,
  output logic        cp0_exl,
  output logic [4:0]  cp0_exc,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic [31:0] cp0_bva,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;       // redirect already accepted by fetch
  logic [31:0]       target_q, target_d;
  logic [4:0]        last_exc_q, last_exc_d;

  logic              int_req, any_exc, commit, accepted_now;
  logic [4:0]        exc_code;
  logic [31:0]       exc_bva, target;

  exc_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hw_int),
    .q_o (hw_int_sync)
  );

  assign int_req = cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL] &
                   (|({hw_int_sync, cp0_cause[CAUSE_SW_HI:CAUSE_SW_LO]} &
                      cp0_status[STATUS_IM_HI:STATUS_IM_LO]));

  assign any_exc = int_req | exc_if_adel | exc_ri | exc_ov | exc_sys |
                   exc_bp | exc_ld_adel | exc_st_ades;

  // Gating with rst keeps every output low for the whole reset pulse even
  // though the commit path is combinational from the MEM inputs.
  assign commit = (state_q == ST_RUN) & mem_valid & ~mem_stall &
                  (any_exc | is_eret) & ~rst;

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    exc_code = EXC_INT;
    exc_bva  = '0;
    if      (int_req)     exc_code = EXC_INT;
    else if (exc_if_adel) begin exc_code = EXC_ADEL; exc_bva = mem_pc;   end
    else if (exc_ri)      exc_code = EXC_RI;
    else if (exc_ov)      exc_code = EXC_OV;
    else if (exc_sys)     exc_code = EXC_SYS;
    else if (exc_bp)      exc_code = EXC_BP;
    else if (exc_ld_adel) begin exc_code = EXC_ADEL; exc_bva = mem_addr; end
    else if (exc_st_ades) begin exc_code = EXC_ADES; exc_bva = mem_addr; end
  end

  assign target = any_exc ? EXC_VECTOR : cp0_epc_r;

  // cp0 commit values; eret keeps ExcCode unchanged by replaying last_exc.
  assign cp0_en  = commit;
  assign cp0_exl = commit & any_exc;
  assign cp0_exc = commit ? (any_exc ? exc_code : last_exc_q) : 5'd0;
  assign cp0_epc = commit ? (any_exc ? (mem_bd ? mem_pc - 32'd4 : mem_pc)
                                     : cp0_epc_r) : 32'd0;
  assign cp0_bd  = commit & any_exc & mem_bd;
  assign cp0_bva = (commit & any_exc) ? exc_bva : 32'd0;

  assign flush          = commit | (state_q == ST_FLUSH);
  assign redirect_valid = commit | ((state_q == ST_FLUSH) & ~acc_q);
  assign redirect_pc    = commit ? target : target_q;

  assign accepted_now = acc_q | redirect_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    target_d   = target_q;
    last_exc_d = last_exc_q;
    case (state_q)
      ST_RUN: begin
        if (commit) begin
          state_d  = ST_FLUSH;
          cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
          acc_d    = redirect_ready;
          target_d = target;
          if (any_exc) last_exc_d = exc_code;
        end
      end
      ST_FLUSH: begin
        acc_d = accepted_now;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        // Leave only once the countdown is done and fetch has the target.
        if (cnt_q == '0 && accepted_now) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      target_q   <= '0;
      last_exc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      target_q   <= target_d;
      last_exc_q <= last_exc_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:10], cp0_cause[7:0]};

endmodule
